eth_mac_tx: RTL

//  Ethernet MAC transmitter that feeds the SGMII PCS TX byte interface (ready/sof/eof/data).

---
 rtl/eth_mac_tx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmitter: buffers one payload, then streams DST/SRC/type/payload/pad/FCS
// to the PCS byte interface without gaps, honouring the inter-frame gap between frames.
module eth_mac_tx #(
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eth_ready,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    input  logic [47:0] dst_mac,
    input  logic [15:0] ethertype,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic [7:0]  tx_data,
    output logic        frame_sent,
    output logic        frame_dropped
);

    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int GW = $clog2(IFG_BYTES + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PAYLOAD);
    localparam logic [LW-1:0] MIN_LEN = LW'(46);
    localparam logic [GW-1:0] GAP_END = GW'(IFG_BYTES);

    typedef enum logic [2:0] {
        S_FILL,
        S_DROP,
        S_ARMED,
        S_HDR,
        S_PAYLOAD,
        S_PAD,
        S_FCS
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   wr_len_q, wr_len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [31:0]     crc_q, crc_d;
    logic [47:0]     dst_q, dst_d;
    logic [15:0]     type_q, type_d;
    logic            sent_q, sent_d;
    logic            dropped_q, dropped_d;
    logic [7:0]      rd_data_q;
    logic [7:0]      pay_mem_q [MAX_PAYLOAD];

    logic            wr_en;
    logic [LW-1:0]   rd_addr;
    logic            s_ready_c;
    logic            gap_done;
    logic [111:0]    hdr_vec;
    logic [31:0]     fcs_vec;

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign gap_done = (gap_q == GAP_END);
    assign hdr_vec  = {dst_q, SRC_MAC, type_q};
    assign fcs_vec  = ~crc_q;

    always_comb begin
        state_d   = state_q;
        wr_len_d  = wr_len_q;
        cnt_d     = cnt_q;
        gap_d     = gap_done ? gap_q : gap_q + GW'(1);
        crc_d     = crc_q;
        dst_d     = dst_q;
        type_d    = type_q;
        sent_d    = 1'b0;
        dropped_d = 1'b0;
        wr_en     = 1'b0;
        rd_addr   = '0;
        s_ready_c = 1'b0;
        tx_sof    = 1'b0;
        tx_eof    = 1'b0;
        tx_data   = 8'h00;

        case (state_q)
            S_FILL: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    // A byte beyond the buffer depth condemns the whole payload.
                    if (wr_len_q == MAX_LEN) begin
                        if (s_last) begin
                            dropped_d = 1'b1;
                            wr_len_d  = '0;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_len_d = wr_len_q + LW'(1);
                        if (wr_len_q == '0) begin
                            dst_d  = dst_mac;
                            type_d = ethertype;
                        end
                        if (s_last) begin
                            state_d = S_ARMED;
                        end
                    end
                end
            end
            S_DROP: begin
                s_ready_c = 1'b1;
                if (s_valid && s_last) begin
                    dropped_d = 1'b1;
                    wr_len_d  = '0;
                    state_d   = S_FILL;
                end
            end
            S_ARMED: begin
                if (gap_done && eth_ready) begin
                    tx_sof  = 1'b1;
                    tx_data = dst_q[47:40];
                    if (tx_ready) begin
                        crc_d   = crcByte(32'hFFFF_FFFF, tx_data);
                        cnt_d   = LW'(1);
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                // Prefetch payload byte 0 so it is ready the cycle PAYLOAD starts.
                tx_data = hdr_vec[111 - 8*int'(cnt_q[3:0]) -: 8];
                crc_d   = crcByte(crc_q, tx_data);
                if (cnt_q == LW'(13)) begin
                    cnt_d   = '0;
                    state_d = S_PAYLOAD;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            S_PAYLOAD: begin
                tx_data = rd_data_q;
                crc_d   = crcByte(crc_q, tx_data);
                rd_addr = cnt_q + LW'(1);
                if (cnt_q == wr_len_q - LW'(1)) begin
                    if (wr_len_q >= MIN_LEN) begin
                        cnt_d   = '0;
                        state_d = S_FCS;
                    end else begin
                        cnt_d   = wr_len_q;
                        state_d = S_PAD;
                    end
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            S_PAD: begin
                tx_data = 8'h00;
                crc_d   = crcByte(crc_q, tx_data);
                if (cnt_q == LW'(45)) begin
                    cnt_d   = '0;
                    state_d = S_FCS;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            S_FCS: begin
                tx_data = fcs_vec[8*int'(cnt_q[1:0]) +: 8];
                if (cnt_q == LW'(3)) begin
                    tx_eof   = 1'b1;
                    cnt_d    = '0;
                    gap_d    = '0;
                    wr_len_d = '0;
                    sent_d   = 1'b1;
                    state_d  = S_FILL;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign s_ready       = s_ready_c & ~reset;
    assign frame_sent    = sent_q;
    assign frame_dropped = dropped_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FILL;
            wr_len_q  <= '0;
            cnt_q     <= '0;
            gap_q     <= GAP_END;
            crc_q     <= 32'hFFFF_FFFF;
            dst_q     <= '0;
            type_q    <= '0;
            sent_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_len_q  <= wr_len_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            crc_q     <= crc_d;
            dst_q     <= dst_d;
            type_q    <= type_d;
            sent_q    <= sent_d;
            dropped_q <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pay_mem_q[wr_len_q] <= s_data;
        end
        rd_data_q <= pay_mem_q[rd_addr];
    end

endmodule
